// File: rtl/led_fader.sv
// LED brightness fader: ramps PWM duty up or down at a fixed tick rate
// in response to an on/off request from the blink-pattern stage.
module led_fader #(
  parameter int unsigned TICK_DIV = 16000,
  parameter int unsigned STEP     = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LED_REQ,
  output logic       LED,
  output logic       BUSY,
  output logic [7:0] LEVEL
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);
  localparam logic [8:0]  STEP9    = 9'(STEP);

  logic        r_req_q;
  logic [15:0] r_tick_cnt;
  logic [7:0]  r_pwm_cnt;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_level;
  logic [7:0]  w_level_nxt;
  logic        r_led;
  logic        r_busy;
  logic        w_led_d;
  logic        w_busy_d;
  logic        w_tick;
  logic [8:0]  w_up;
  logic [8:0]  w_dn;

  assign w_tick = (r_tick_cnt == TICK_MAX);
  assign w_up   = {1'b0, r_level} + STEP9;
  assign w_dn   = {1'b0, r_level} - STEP9;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_req_q    <= 1'b0;
      r_tick_cnt <= '0;
      r_pwm_cnt  <= '0;
    end else begin
      r_req_q    <= LED_REQ;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 16'd1;
      r_pwm_cnt  <= r_pwm_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_OFF;
      r_level <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
    end
  end

  // In a ramp the direction always follows req_q, so a reversal
  // coinciding with a tick steps the new way from the current level.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    unique case (r_state)
      S_OFF: begin
        if (r_req_q) w_state_nxt = S_UP;
      end
      S_ON: begin
        if (!r_req_q) w_state_nxt = S_DOWN;
      end
      default: begin
        if (r_req_q) begin
          if (w_tick) w_level_nxt = w_up[8] ? 8'hFF : w_up[7:0];
          w_state_nxt = (w_level_nxt == 8'hFF) ? S_ON : S_UP;
        end else begin
          if (w_tick) w_level_nxt = w_dn[8] ? 8'h00 : w_dn[7:0];
          w_state_nxt = (w_level_nxt == 8'h00) ? S_OFF : S_DOWN;
        end
      end
    endcase
  end

  always_comb begin
    w_busy_d = (r_state == S_UP) || (r_state == S_DOWN);
    w_led_d  = (r_level == 8'hFF) || (r_pwm_cnt < r_level);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_led  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_led  <= w_led_d;
      r_busy <= w_busy_d;
    end
  end

  assign LED   = r_led;
  assign BUSY  = r_busy;
  assign LEVEL = r_level;

endmodule

// File: tb/tb_led_fader.sv
// Randomized bench for led_fader against a cycle-level behavioural model,
// plus directed runs on fast-step and slow-tick instances.
module tb_led_fader;

  localparam int TD  = 4;
  localparam int STP = 64;

  localparam int M_OFF  = 0;
  localparam int M_UP   = 1;
  localparam int M_ON   = 2;
  localparam int M_DOWN = 3;

  logic       clk = 1'b0;
  logic       rst_m = 1'b1;
  logic       req_m = 1'b0;
  logic       led_m;
  logic       busy_m;
  logic [7:0] lvl_m;

  logic       rst_f = 1'b1;
  logic       req_f = 1'b0;
  logic       led_f;
  logic       busy_f;
  logic [7:0] lvl_f;

  logic       rst_s = 1'b1;
  logic       req_s = 1'b0;
  logic       led_s;
  logic       busy_s;
  logic [7:0] lvl_s;

  int n_err = 0;
  int n_chk = 0;

  int m_req_q, m_tcnt, m_pwm, m_level, m_mode, m_led, m_busy;

  always #5 clk = ~clk;

  led_fader #(.TICK_DIV(TD), .STEP(STP)) u_dut (
    .CLK(clk), .RST(rst_m), .LED_REQ(req_m),
    .LED(led_m), .BUSY(busy_m), .LEVEL(lvl_m)
  );

  led_fader #(.TICK_DIV(2), .STEP(255)) u_fast (
    .CLK(clk), .RST(rst_f), .LED_REQ(req_f),
    .LED(led_f), .BUSY(busy_f), .LEVEL(lvl_f)
  );

  led_fader #(.TICK_DIV(1000), .STEP(64)) u_slow (
    .CLK(clk), .RST(rst_s), .LED_REQ(req_s),
    .LED(led_s), .BUSY(busy_s), .LEVEL(lvl_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the intended behaviour, from the requirement rules.
  task automatic model_step(input bit rst, input bit req);
    int lvl;
    int mode;
    bit tick;
    if (rst) begin
      m_req_q = 0; m_tcnt = 0; m_pwm = 0;
      m_level = 0; m_mode = M_OFF; m_led = 0; m_busy = 0;
      return;
    end
    tick = (m_tcnt == TD - 1);
    lvl  = m_level;
    mode = m_mode;
    m_busy = (m_mode == M_UP || m_mode == M_DOWN) ? 1 : 0;
    m_led  = (m_level == 255 || m_pwm < m_level) ? 1 : 0;
    case (m_mode)
      M_OFF: if (m_req_q == 1) mode = M_UP;
      M_ON:  if (m_req_q == 0) mode = M_DOWN;
      default: begin
        if (tick) begin
          if (m_req_q == 1) lvl = (lvl + STP > 255) ? 255 : lvl + STP;
          else              lvl = (lvl - STP < 0) ? 0 : lvl - STP;
        end
        if (m_req_q == 1) mode = (lvl == 255) ? M_ON : M_UP;
        else              mode = (lvl == 0) ? M_OFF : M_DOWN;
      end
    endcase
    m_tcnt  = (m_tcnt + 1) % TD;
    m_pwm   = (m_pwm + 1) % 256;
    m_req_q = req;
    m_level = lvl;
    m_mode  = mode;
  endtask

  task automatic cyc(input bit r, input bit q);
    rst_m = r;
    req_m = q;
    @(posedge clk);
    model_step(r, q);
    #1;
    chk("level", int'(lvl_m), m_level);
    chk("busy", int'(busy_m), m_busy);
    chk("led", int'(led_m), m_led);
  endtask

  initial begin
    int busy_at;
    int guard;
    int nbusy;
    int bad;
    int ones;
    int rises;
    bit smp [256];
    bit rr;
    bit qq;

    model_step(1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    chk("rst_level", int'(lvl_m), 0);
    chk("rst_busy", int'(busy_m), 0);

    // Hold request from release: ramp to full brightness
    busy_at = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc(1'b0, 1'b1);
      if (busy_at < 0 && busy_m) busy_at = i;
    end
    chk("busy_rise", busy_at, 3);
    chk("on_level", int'(lvl_m), 255);
    chk("on_busy", int'(busy_m), 0);

    // Release: ramp down, then LED stays dark
    repeat (30) cyc(1'b0, 1'b0);
    chk("off_level", int'(lvl_m), 0);
    ones = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b0);
      ones += int'(led_m);
    end
    chk("off_led_dark", ones, 0);

    // One-cycle request drop at level 128 during the up ramp
    guard = 0;
    do begin
      cyc(1'b0, 1'b1);
      guard++;
    end while (lvl_m != 8'd128 && guard < 60);
    chk("reach128", int'(lvl_m), 128);
    cyc(1'b0, 1'b0);
    repeat (40) cyc(1'b0, 1'b1);

    // Reset at level 192 with a coincident tick
    repeat (30) cyc(1'b0, 1'b0);
    guard = 0;
    do begin
      cyc(1'b0, 1'b1);
      guard++;
    end while (!(lvl_m == 8'd192 && m_tcnt == TD - 1) && guard < 60);
    chk("reach192", int'(lvl_m), 192);
    cyc(1'b1, 1'b1);
    chk("rst_mid_level", int'(lvl_m), 0);
    chk("rst_mid_busy", int'(busy_m), 0);
    chk("rst_mid_led", int'(led_m), 0);
    repeat (30) cyc(1'b0, 1'b1);

    // Random requests, reversals and occasional resets
    qq = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 11) == 0) qq = ~qq;
      cyc(rr, qq);
    end

    // Fast instance: one tick takes LEVEL from 0 to 255
    repeat (2) @(posedge clk);
    #1;
    chk("fast_rst_level", int'(lvl_f), 0);
    rst_f = 1'b0;
    req_f = 1'b1;
    nbusy = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      nbusy += int'(busy_f);
      if (lvl_f != 8'd0 && lvl_f != 8'd255) bad++;
    end
    chk("fast_level", int'(lvl_f), 255);
    chk("fast_busy_len", (nbusy >= 1 && nbusy <= 2) ? 1 : 0, 1);
    chk("fast_nowrap", bad, 0);
    chk("fast_led", int'(led_f), 1);

    // Slow instance: LEVEL sits at 64 long enough to measure duty
    rst_s = 1'b0;
    req_s = 1'b1;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (lvl_s != 8'd64 && guard < 1300);
    chk("slow_reach64", int'(lvl_s), 64);
    repeat (10) @(posedge clk);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      smp[i] = led_s;
    end
    chk("slow_hold64", int'(lvl_s), 64);
    ones = 0;
    rises = 0;
    for (int i = 0; i < 256; i++) begin
      ones += int'(smp[i]);
      if (smp[i] && !smp[(i + 255) % 256]) rises++;
    end
    chk("duty64_ones", ones, 64);
    chk("duty64_contig", rises, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
